// File: rtl/riscv_uop_pkg.sv
// Shared micro-op types plus LSU size/state encodings and exception causes.
package riscv_uop_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        EXC
    } lsu_state_e;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic [4:0] rd;
    } uop_t;

    localparam int unsigned UOP_W = $bits(uop_t);

    // Size code 2'b11 is treated as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            2'(MEM_B): mis = 1'b0;
            2'(MEM_H): mis = offset[0];
            default:   mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align_unit.sv
// Combinational lane steering: store byte-enables/replicated data and
// load-data shift with sign/zero extension.
module lsu_align_unit
    import riscv_uop_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_offset,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            2'(MEM_B): begin
                st_be    = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            2'(MEM_H): begin
                st_be    = 4'b0011 << st_offset;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = ld_rdata >> {ld_offset, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (ld_size)
            2'(MEM_B): ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
            2'(MEM_H): ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: single-outstanding dmem bus FSM with misalignment traps.
// Optional bus watchdog enabled by defining LSU_BUS_TIMEOUT_EN.
module lsu_mem_stage
    import riscv_uop_pkg::*;
#(
    parameter int unsigned XLEN = 32
`ifdef LSU_BUS_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m_valid,
    input  logic [UOP_W-1:0] m_uop,
    input  logic [XLEN-1:0]  m_pc,
    input  logic [XLEN-1:0]  m_addr_base,
    input  logic [XLEN-1:0]  m_store_data,
    output logic             s_stall_from_lsu,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  wb_pc,
    output logic             exc_valid,
    output logic [3:0]       exc_cause,
    output logic [XLEN-1:0]  exc_tval,
    output logic [XLEN-1:0]  exc_pc
);

    uop_t            uop;
    lsu_state_e      state;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q;
    logic            accept;
    logic            misaligned;
    logic            is_st;
    logic            timeout;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_data;

    assign uop              = uop_t'(m_uop);
    assign accept           = m_valid && (state == IDLE) && (uop.is_load || uop.is_store);
    assign misaligned       = is_misaligned(uop.mem_size, m_addr_base[1:0]);
    assign is_st            = uop.is_store && !uop.is_load;
    assign s_stall_from_lsu = (state != IDLE);

    lsu_align_unit u_align (
        .st_offset   (m_addr_base[1:0]),
        .st_size     (uop.mem_size),
        .st_data     (m_store_data),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .ld_offset   (off_q),
        .ld_size     (size_q),
        .ld_unsigned (unsigned_q),
        .ld_rdata    (dmem_rdata),
        .ld_data     (ld_data)
    );

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;
    logic [XLEN-1:0] addr_q;

    assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent waiting on the bus; restarts on every REQ/WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == IDLE || (state == REQ && dmem_gnt)) begin
            to_cnt <= '0;
        end else if (state == REQ || state == WAIT) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= m_addr_base;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            off_q      <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            rd_q       <= '0;
            pc_q       <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_pc      <= '0;
            exc_valid  <= 1'b0;
            exc_cause  <= '0;
            exc_tval   <= '0;
            exc_pc     <= '0;
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        off_q      <= m_addr_base[1:0];
                        size_q     <= uop.mem_size;
                        unsigned_q <= uop.mem_unsigned;
                        rd_q       <= uop.rd;
                        pc_q       <= m_pc;
                        if (misaligned) begin
                            state     <= EXC;
                            exc_valid <= 1'b1;
                            exc_cause <= uop.is_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
                            exc_tval  <= m_addr_base;
                            exc_pc    <= m_pc;
                        end else begin
                            state      <= REQ;
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_st;
                            dmem_addr  <= {m_addr_base[XLEN-1:2], 2'b00};
                            dmem_be    <= st_be;
                            dmem_wdata <= is_st ? st_wdata : '0;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        state    <= dmem_we ? IDLE : WAIT;
                    end else if (timeout) begin
                        dmem_req  <= 1'b0;
                        state     <= EXC;
                        exc_valid <= 1'b1;
                        exc_cause <= dmem_we ? EXC_ST_FAULT : EXC_LD_FAULT;
`ifdef LSU_BUS_TIMEOUT_EN
                        exc_tval  <= addr_q;
`endif
                        exc_pc    <= pc_q;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= ld_data;
                        wb_pc    <= pc_q;
                    end else if (timeout) begin
                        state     <= EXC;
                        exc_valid <= 1'b1;
                        exc_cause <= EXC_LD_FAULT;
`ifdef LSU_BUS_TIMEOUT_EN
                        exc_tval  <= addr_q;
`endif
                        exc_pc    <= pc_q;
                    end
                end
                EXC: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed vector table, corner sequences, random ops.
module tb_lsu_mem_stage;
    import riscv_uop_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             m_valid;
    logic [UOP_W-1:0] m_uop;
    logic [31:0]      m_pc, m_addr_base, m_store_data;
    logic             s_stall_from_lsu;
    logic             dmem_req, dmem_we;
    logic [31:0]      dmem_addr;
    logic [3:0]       dmem_be;
    logic [31:0]      dmem_wdata;
    logic             dmem_gnt, dmem_rvalid;
    logic [31:0]      dmem_rdata;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data, wb_pc;
    logic             exc_valid;
    logic [3:0]       exc_cause;
    logic [31:0]      exc_tval, exc_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef LSU_BUS_TIMEOUT_EN
    lsu_mem_stage #(.TIMEOUT_CYCLES(8)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m_valid          (m_valid),
        .m_uop            (m_uop),
        .m_pc             (m_pc),
        .m_addr_base      (m_addr_base),
        .m_store_data     (m_store_data),
        .s_stall_from_lsu (s_stall_from_lsu),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .wb_pc            (wb_pc),
        .exc_valid        (exc_valid),
        .exc_cause        (exc_cause),
        .exc_tval         (exc_tval),
        .exc_pc           (exc_pc)
    );
`else
    lsu_mem_stage u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m_valid          (m_valid),
        .m_uop            (m_uop),
        .m_pc             (m_pc),
        .m_addr_base      (m_addr_base),
        .m_store_data     (m_store_data),
        .s_stall_from_lsu (s_stall_from_lsu),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .wb_pc            (wb_pc),
        .exc_valid        (exc_valid),
        .exc_cause        (exc_cause),
        .exc_tval         (exc_tval),
        .exc_pc           (exc_pc)
    );
`endif

    typedef struct {
        logic [31:0] ld, st, sz, uns, rd, pc, addr, sdata, rdata, gd, rvd;
        logic [31:0] ebe, ewd, ewb, eexc, ecause;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: byte count, alignment, lane enables, replication, load extension.
    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] addr);
        return (addr % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
        int unsigned n = nbytes(sz);
        if (n == 4) return 32'hF;
        return ((32'd1 << n) - 32'd1) << (addr % 4);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        int unsigned n = nbytes(sz);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v, mask;
        int unsigned n = nbytes(sz);
        v = rdata >> (8 * (addr % 4));
        if (n < 4) begin
            mask = (32'd1 << (8 * n)) - 32'd1;
            v = v & mask;
            if (!uns && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // Starts and ends on a falling edge; walks the whole bus handshake.
    task automatic run_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int gd,
                          input int rvd, input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] ewb, input logic eexc, input logic [3:0] ecause);
        uop_t u;
        u.is_load = ld; u.is_store = st; u.mem_size = sz; u.mem_unsigned = uns; u.rd = rd;
        chk("idle_stall", 32'(s_stall_from_lsu), 32'd0);
        m_valid = 1'b1; m_uop = u; m_pc = pc; m_addr_base = addr; m_store_data = sdata;
        @(negedge clk);
        m_valid = 1'b0; m_uop = UOP_W'($urandom);
        chk("wb_single_pulse", 32'(wb_valid), 32'd0);
        if (eexc) begin
            chk("exc_valid", 32'(exc_valid), 32'd1);
            chk("exc_cause", 32'(exc_cause), 32'(ecause));
            chk("exc_tval", exc_tval, addr);
            chk("exc_pc", exc_pc, pc);
            chk("exc_no_req", 32'(dmem_req), 32'd0);
            chk("exc_stall", 32'(s_stall_from_lsu), 32'd1);
            @(negedge clk);
            chk("exc_pulse_end", 32'(exc_valid), 32'd0);
            chk("exc_stall_end", 32'(s_stall_from_lsu), 32'd0);
            chk("exc_no_req2", 32'(dmem_req), 32'd0);
            return;
        end
        chk("no_exc", 32'(exc_valid), 32'd0);
        for (int k = 0; k <= gd; k++) begin
            chk("req", 32'(dmem_req), 32'd1);
            chk("req_we", 32'(dmem_we), 32'(st));
            chk("req_addr", dmem_addr, {addr[31:2], 2'b00});
            chk("req_be", 32'(dmem_be), 32'(ebe));
            chk("req_wdata", dmem_wdata, ewd);
            chk("req_stall", 32'(s_stall_from_lsu), 32'd1);
            dmem_gnt = (k == gd);
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        chk("req_drop", 32'(dmem_req), 32'd0);
        if (st) begin
            chk("st_done_stall", 32'(s_stall_from_lsu), 32'd0);
            chk("st_no_wb", 32'(wb_valid), 32'd0);
            return;
        end
        for (int k = 0; k <= rvd; k++) begin
            chk("wait_stall", 32'(s_stall_from_lsu), 32'd1);
            chk("wait_no_wb", 32'(wb_valid), 32'd0);
            dmem_rvalid = (k == rvd);
            dmem_rdata  = (k == rvd) ? rdata : $urandom;
            @(negedge clk);
        end
        dmem_rvalid = 1'b0;
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_rd", 32'(wb_rd), 32'(rd));
        chk("wb_data", wb_data, ewb);
        chk("wb_pc", wb_pc, pc);
        chk("ld_done_stall", 32'(s_stall_from_lsu), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; m_valid = 1'b0; m_uop = '0; m_pc = '0; m_addr_base = '0;
        m_store_data = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        //        ld st sz uns rd pc      addr     sdata         rdata         gd rvd be      wdata         wb            exc cause
        vecs[0]  = '{1, 0, 0, 0, 1, 'h100, 'h1003, 0,            'h80FFFF00,   0, 0, 'b1000, 0,            'hFFFFFF80,   0, 0};
        vecs[1]  = '{0, 1, 1, 0, 2, 'h104, 'h2002, 'h1234ABCD,   0,            0, 0, 'b1100, 'hABCDABCD,   0,            0, 0};
        vecs[2]  = '{1, 0, 2, 0, 3, 'h108, 'h1001, 0,            0,            0, 0, 0,      0,            0,            1, 4};
        vecs[3]  = '{1, 0, 1, 1, 4, 'h10C, 'h3002, 0,            'h80010000,   3, 0, 'b1100, 0,            'h00008001,   0, 0};
        vecs[4]  = '{0, 1, 0, 0, 5, 'h110, 'h4001, 'h000000A5,   0,            1, 0, 'b0010, 'hA5A5A5A5,   0,            0, 0};
        vecs[5]  = '{0, 1, 2, 0, 6, 'h114, 'h5002, 1,            0,            0, 0, 0,      0,            0,            1, 6};
        vecs[6]  = '{1, 0, 1, 0, 7, 'h118, 'h6000, 0,            'h1234F00D,   0, 1, 'b0011, 0,            'hFFFFF00D,   0, 0};
        vecs[7]  = '{1, 0, 0, 1, 8, 'h11C, 'h7002, 0,            'h00AB0000,   2, 2, 'b0100, 0,            'h000000AB,   0, 0};
        vecs[8]  = '{1, 0, 3, 0, 0, 'h120, 'h8004, 0,            'hDEADBEEF,   1, 0, 'b1111, 0,            'hDEADBEEF,   0, 0};
        vecs[9]  = '{0, 1, 1, 0, 9, 'h124, 'h9001, 'h55,         0,            0, 0, 0,      0,            0,            1, 6};
        vecs[10] = '{0, 1, 2, 0, 10,'h128, 'hA000, 'hCAFEF00D,   0,            0, 0, 'b1111, 'hCAFEF00D,   0,            0, 0};
        vecs[11] = '{1, 0, 1, 0, 11,'h12C, 'hB003, 0,            0,            0, 0, 0,      0,            0,            1, 4};
        vecs[12] = '{1, 0, 0, 1, 12,'h130, 'hC001, 0,            'h00008000,   0, 0, 'b0010, 0,            'h00000080,   0, 0};

        #3;
        chk("rst_stall", 32'(s_stall_from_lsu), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_exc_valid", 32'(exc_valid), 32'd0);
        chk("rst_exc_cause", 32'(exc_cause), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_op(1'(vecs[i].ld), 1'(vecs[i].st), 2'(vecs[i].sz), 1'(vecs[i].uns), 5'(vecs[i].rd),
                   vecs[i].pc, vecs[i].addr, vecs[i].sdata, vecs[i].rdata, int'(vecs[i].gd),
                   int'(vecs[i].rvd), 4'(vecs[i].ebe), vecs[i].ewd, vecs[i].ewb,
                   1'(vecs[i].eexc), 4'(vecs[i].ecause));

        // Valid with no load/store flag, plus a stray rvalid while idle: both ignored.
        m_valid = 1'b1; m_uop = '0; m_addr_base = 32'h1001; dmem_rvalid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0; dmem_rvalid = 1'b0;
        chk("nop_stall", 32'(s_stall_from_lsu), 32'd0);
        chk("nop_req", 32'(dmem_req), 32'd0);
        chk("nop_exc", 32'(exc_valid), 32'd0);
        chk("nop_wb", 32'(wb_valid), 32'd0);

        // Reset while in WAIT, then a late rvalid after release.
        begin
            uop_t u;
            u = '{is_load: 1'b1, is_store: 1'b0, mem_size: 2'd2, mem_unsigned: 1'b0, rd: 5'd7};
            m_valid = 1'b1; m_uop = u; m_addr_base = 32'h0000_0100; m_pc = 32'h200;
            @(negedge clk);
            m_valid = 1'b0; dmem_gnt = 1'b1;
            @(negedge clk);
            dmem_gnt = 1'b0;
            chk("prerst_wait_stall", 32'(s_stall_from_lsu), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("midrst_stall", 32'(s_stall_from_lsu), 32'd0);
            chk("midrst_req", 32'(dmem_req), 32'd0);
            chk("midrst_addr", dmem_addr, 32'd0);
            chk("midrst_wb", 32'(wb_valid), 32'd0);
            @(negedge clk);
            rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
            @(negedge clk);
            dmem_rvalid = 1'b0;
            chk("late_rvalid_wb", 32'(wb_valid), 32'd0);
            chk("late_rvalid_stall", 32'(s_stall_from_lsu), 32'd0);
            run_op(1'b1, 1'b0, 2'd2, 1'b0, 5'd9, 32'h204, 32'h0000_0300, 32'd0, 32'h89AB_CDEF,
                   0, 0, 4'hF, 32'd0, 32'h89AB_CDEF, 1'b0, 4'd0);
        end

`ifdef LSU_BUS_TIMEOUT_EN
        // Store whose grant never arrives: watchdog fault after 8 REQ cycles.
        begin
            uop_t u;
            u = '{is_load: 1'b0, is_store: 1'b1, mem_size: 2'd2, mem_unsigned: 1'b0, rd: 5'd0};
            m_valid = 1'b1; m_uop = u; m_addr_base = 32'h0000_0440; m_pc = 32'h300;
            m_store_data = 32'h1111_2222;
            @(negedge clk);
            m_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                chk("to_req_held", 32'(dmem_req), 32'd1);
                @(negedge clk);
            end
            chk("to_exc_valid", 32'(exc_valid), 32'd1);
            chk("to_exc_cause", 32'(exc_cause), 32'd7);
            chk("to_exc_tval", exc_tval, 32'h0000_0440);
            chk("to_exc_pc", exc_pc, 32'h300);
            chk("to_req_drop", 32'(dmem_req), 32'd0);
            @(negedge clk);
            chk("to_idle", 32'(s_stall_from_lsu), 32'd0);
            chk("to_exc_end", 32'(exc_valid), 32'd0);
        end
`endif

        for (int n = 0; n < 200; n++) begin
            logic        ld, uns;
            logic [1:0]  sz;
            logic [4:0]  rd;
            logic [31:0] addr, sdata, rdata, pc;
            ld = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3)); rd = 5'($urandom);
            addr = $urandom; sdata = $urandom; rdata = $urandom; pc = $urandom;
            run_op(ld, !ld, sz, uns, rd, pc, addr, sdata, rdata,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   4'(model_be(sz, addr)), ld ? 32'd0 : model_wdata(sz, sdata),
                   model_load(sz, uns, addr, rdata), model_mis(sz, addr),
                   ld ? 4'd4 : 4'd6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
